// File: rtl/wrapped_instrumented_adder_kogge_spec.sv
`default_nettype none
// ============================================================================
// Module   : wrapped_instrumented_adder_kogge_spec
// Brief    : Register-programmed 32-bit Kogge-Stone adder with chain feedback,
//            cycle/toggle counters, run time limit and a tristating wrapper.
//            Optional macro COUNTERS_EN adds the chain toggle counter.
// Revision : 1.0 - initial release
// ============================================================================
module wrapped_instrumented_adder_kogge_spec (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        active,
  input  logic [31:0] la1_data_in,
  input  logic [31:0] la2_data_in,
  input  logic [31:0] la3_data_in,
  input  logic [31:0] la1_oenb,
  input  logic [31:0] la2_oenb,
  input  logic [31:0] la3_oenb,
  input  logic [37:0] io_in,
  output logic [31:0] la1_data_out,
  output logic [31:0] la2_data_out,
  output logic [31:0] la3_data_out,
  output logic [37:0] io_out,
  output logic [37:0] io_oeb
);

  localparam logic [2:0]  c_SEL_A    = 3'd0;
  localparam logic [2:0]  c_SEL_B    = 3'd1;
  localparam logic [2:0]  c_SEL_EXT  = 3'd2;
  localparam logic [2:0]  c_SEL_RING = 3'd3;
  localparam logic [2:0]  c_SEL_S    = 3'd4;
  localparam logic [2:0]  c_SEL_CTRL = 3'd5;
  localparam logic [2:0]  c_SEL_TLIM = 3'd6;
  localparam logic [31:0] c_SAT      = 32'hFFFF_FFFF;

  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] ext_mask_q, ext_mask_d;
  logic [31:0] ring_mask_q, ring_mask_d;
  logic [31:0] s_mask_q, s_mask_d;
  logic [31:0] time_limit_q, time_limit_d;
  logic [31:0] cyc_cnt_q, cyc_cnt_d;
  logic        run_q, run_d;
  logic        done_q, done_d;
  logic        chain_q, chain_d;

  logic        w_we;
  logic [2:0]  w_sel;
  logic        w_cnt_clr;
  logic        w_limit_hit;
  logic        w_chain_next;
  logic [31:0] w_a_eff;
  logic [31:0] w_g0, w_p0, w_gfin;
  logic [32:0] w_sum;
  logic [31:0] w_tog_out;

  assign w_we      = la3_data_in[3];
  assign w_sel     = la3_data_in[2:0];
  assign w_cnt_clr = w_we && (w_sel == c_SEL_CTRL) && la1_data_in[1];

  // Ring bits take priority over external bits; unselected bits are zero.
  assign w_a_eff = (ring_mask_q & {32{chain_q}}) | (~ring_mask_q & ext_mask_q & a_q);

  assign w_g0 = w_a_eff & b_q;
  assign w_p0 = w_a_eff ^ b_q;

  generate
    for (genvar l = 0; l < 5; l++) begin : g_level
      logic [31:0] g_in, p_in, g_out, p_out;
      if (l == 0) begin : g_first
        assign g_in = w_g0;
        assign p_in = w_p0;
      end else begin : g_next
        assign g_in = g_level[l-1].g_out;
        assign p_in = g_level[l-1].p_out;
      end
      for (genvar i = 0; i < 32; i++) begin : g_bit
        if (i >= (1 << l)) begin : g_merge
          assign g_out[i] = g_in[i] | (p_in[i] & g_in[i-(1<<l)]);
          assign p_out[i] = p_in[i] & p_in[i-(1<<l)];
        end else begin : g_pass
          assign g_out[i] = g_in[i];
          assign p_out[i] = p_in[i];
        end
      end
    end
  endgenerate

  // Carry-in is zero, so the group generate at bit i is the carry into bit i+1.
  assign w_gfin = g_level[4].g_out;
  assign w_sum  = {w_gfin[31], w_p0 ^ {w_gfin[30:0], 1'b0}};

  assign w_chain_next = ~(^(w_sum[31:0] & s_mask_q));
  assign w_limit_hit  = (time_limit_q != 32'd0) && (cyc_cnt_q >= time_limit_q);

  always_comb begin
    a_d          = a_q;
    b_d          = b_q;
    ext_mask_d   = ext_mask_q;
    ring_mask_d  = ring_mask_q;
    s_mask_d     = s_mask_q;
    time_limit_d = time_limit_q;
    cyc_cnt_d    = cyc_cnt_q;
    run_d        = run_q;
    done_d       = done_q;
    chain_d      = run_q ? w_chain_next : 1'b0;

    if (run_q) begin
      if (w_limit_hit) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end else if (cyc_cnt_q != c_SAT) begin
        cyc_cnt_d = cyc_cnt_q + 32'd1;
      end
    end

    if (w_we) begin
      case (w_sel)
        c_SEL_A:    a_d          = la1_data_in;
        c_SEL_B:    b_d          = la1_data_in;
        c_SEL_EXT:  ext_mask_d   = la1_data_in;
        c_SEL_RING: ring_mask_d  = la1_data_in;
        c_SEL_S:    s_mask_d     = la1_data_in;
        c_SEL_CTRL: begin
          run_d = la1_data_in[0];
          if (la1_data_in[0]) done_d = 1'b0;
        end
        c_SEL_TLIM: time_limit_d = la1_data_in;
        default: ;
      endcase
    end

    if (w_cnt_clr) cyc_cnt_d = 32'd0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      a_q          <= '0;
      b_q          <= '0;
      ext_mask_q   <= '0;
      ring_mask_q  <= '0;
      s_mask_q     <= '0;
      time_limit_q <= '0;
      cyc_cnt_q    <= '0;
      run_q        <= 1'b0;
      done_q       <= 1'b0;
      chain_q      <= 1'b0;
    end else begin
      a_q          <= a_d;
      b_q          <= b_d;
      ext_mask_q   <= ext_mask_d;
      ring_mask_q  <= ring_mask_d;
      s_mask_q     <= s_mask_d;
      time_limit_q <= time_limit_d;
      cyc_cnt_q    <= cyc_cnt_d;
      run_q        <= run_d;
      done_q       <= done_d;
      chain_q      <= chain_d;
    end
  end

`ifdef COUNTERS_EN
  logic [31:0] tog_cnt_q, tog_cnt_d;

  // The stopping edge counts neither cycles nor toggles.
  always_comb begin
    tog_cnt_d = tog_cnt_q;
    if (run_q && !w_limit_hit && (chain_d != chain_q) && (tog_cnt_q != c_SAT))
      tog_cnt_d = tog_cnt_q + 32'd1;
    if (w_cnt_clr) tog_cnt_d = 32'd0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) tog_cnt_q <= '0;
    else          tog_cnt_q <= tog_cnt_d;
  end

  assign w_tog_out = tog_cnt_q;
`else
  assign w_tog_out = 32'd0;
`endif

  // Reset forces outputs low combinationally so they read zero before the first reset edge.
  assign la1_data_out = !active ? 'z : (wb_rst_i ? 32'd0 : w_sum[31:0]);
  assign la2_data_out = !active ? 'z : (wb_rst_i ? 32'd0 : w_tog_out);
  assign la3_data_out = !active ? 'z : (wb_rst_i ? 32'd0 : cyc_cnt_q);
  assign io_out       = !active ? 'z :
                        (wb_rst_i ? 38'd0 : {27'd0, w_sum[32], done_q, chain_q, 8'd0});
  assign io_oeb       = !active ? 'z : 38'd0;

  logic w_unused_ok;
  assign w_unused_ok = ^{la2_data_in, la1_oenb, la2_oenb, la3_oenb, io_in,
                         la3_data_in[31:4], g_level[4].p_out};

endmodule
`default_nettype wire

// File: tb/tb_wrapped_instrumented_adder_kogge_spec.sv
`default_nettype none
// ============================================================================
// Module   : tb_wrapped_instrumented_adder_kogge_spec
// Brief    : Table, directed and randomized checks against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wrapped_instrumented_adder_kogge_spec;

  localparam logic [2:0] c_A = 3'd0, c_B = 3'd1, c_EXT = 3'd2, c_RING = 3'd3,
                         c_S = 3'd4, c_CTRL = 3'd5, c_TLIM = 3'd6;

  logic        clk = 1'b0;
  logic        rst, active;
  logic [31:0] la1_in, la2_in, la3_in, la1_oenb, la2_oenb, la3_oenb;
  logic [37:0] io_in;
  wire  [31:0] la1_out, la2_out, la3_out;
  wire  [37:0] io_out, io_oeb;

  always #5 clk = ~clk;

  wrapped_instrumented_adder_kogge_spec dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .active      (active),
    .la1_data_in (la1_in),
    .la2_data_in (la2_in),
    .la3_data_in (la3_in),
    .la1_oenb    (la1_oenb),
    .la2_oenb    (la2_oenb),
    .la3_oenb    (la3_oenb),
    .io_in       (io_in),
    .la1_data_out(la1_out),
    .la2_data_out(la2_out),
    .la3_data_out(la3_out),
    .io_out      (io_out),
    .io_oeb      (io_oeb)
  );

  typedef struct packed {
    logic [31:0] a, b, ext, ring, s, lim, cyc, tog;
    logic        run, done, chain;
  } mst_t;

  typedef struct packed {
    logic [31:0] a, b, ext, ring, exp_sum;
    logic        exp_co;
  } tv_t;

  mst_t m;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [37:0] act, input logic [37:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] msum(input mst_t c);
    logic [31:0] eff;
    for (int i = 0; i < 32; i++)
      eff[i] = c.ring[i] ? c.chain : (c.ext[i] ? c.a[i] : 1'b0);
    return {1'b0, eff} + {1'b0, c.b};
  endfunction

  function automatic mst_t step(input mst_t c, input logic r, input logic we,
                                input logic [2:0] sel, input logic [31:0] d);
    mst_t        n;
    logic [32:0] s;
    logic        nch;
    n = c;
    if (r) return '0;
    s   = msum(c);
    nch = c.run ? ~(^(s[31:0] & c.s)) : 1'b0;
    n.chain = nch;
    if (c.run) begin
      if (c.lim != 0 && c.cyc >= c.lim) begin
        n.run  = 1'b0;
        n.done = 1'b1;
      end else begin
        if (c.cyc != 32'hFFFF_FFFF) n.cyc = c.cyc + 1;
        if (nch != c.chain && c.tog != 32'hFFFF_FFFF) n.tog = c.tog + 1;
      end
    end
    if (we) begin
      case (sel)
        c_A:    n.a    = d;
        c_B:    n.b    = d;
        c_EXT:  n.ext  = d;
        c_RING: n.ring = d;
        c_S:    n.s    = d;
        c_CTRL: begin
          n.run = d[0];
          if (d[0]) n.done = 1'b0;
          if (d[1]) begin n.cyc = 0; n.tog = 0; end
        end
        c_TLIM: n.lim  = d;
        default: ;
      endcase
    end
    return n;
  endfunction

  // One clock: drive inputs, advance the model, settle just after the edge.
  task automatic cyc(input logic r, input logic we, input logic [2:0] sel, input logic [31:0] d);
    mst_t        n;
    logic [31:0] junk;
    junk     = $urandom;
    rst      = r;
    la3_in   = {junk[27:0], we, sel};
    la1_in   = d;
    la2_in   = $urandom;
    la1_oenb = $urandom;
    io_in    = {6'h2A, junk};
    n = step(m, r, we, sel, d);
    @(posedge clk);
    #1;
    m      = n;
    rst    = 1'b0;
    la3_in = 32'd0;
  endtask

  task automatic wr(input logic [2:0] sel, input logic [31:0] d);
    cyc(1'b0, 1'b1, sel, d);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 3'd0, $urandom);
  endtask

  task automatic check_all(input string tag);
    logic [32:0] s;
    logic [31:0] e2;
    s = msum(m);
`ifdef COUNTERS_EN
    e2 = m.tog;
`else
    e2 = 32'd0;
`endif
    chk({tag, ".sum"},    {6'd0, la1_out}, {6'd0, s[31:0]});
    chk({tag, ".toggle"}, {6'd0, la2_out}, {6'd0, e2});
    chk({tag, ".cycles"}, {6'd0, la3_out}, {6'd0, m.cyc});
    chk({tag, ".io_out"}, io_out, {27'd0, s[32], m.done, m.chain, 8'd0});
    chk({tag, ".io_oeb"}, io_oeb, 38'd0);
  endtask

  tv_t  tv [8];
  logic zok;

  initial begin
    tv[0] = '{32'h5,        32'h7,        32'hFFFF_FFFF, 32'h0,         32'hC,         1'b0};
    tv[1] = '{32'hFFFF_FFFF,32'h1,        32'hFFFF_FFFF, 32'h0,         32'h0,         1'b1};
    tv[2] = '{32'hFFFF_FFFF,32'hFFFF_FFFF,32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFE, 1'b1};
    tv[3] = '{32'h1234_5678,32'h0,        32'h0000_FFFF, 32'h0,         32'h0000_5678, 1'b0};
    tv[4] = '{32'h8000_0000,32'h8000_0000,32'hFFFF_FFFF, 32'h0,         32'h0,         1'b1};
    tv[5] = '{32'hFFFF_FFFF,32'h0000_0003,32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h3,         1'b0};
    tv[6] = '{32'h7FFF_FFFF,32'h1,        32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0};
    tv[7] = '{32'hAAAA_AAAA,32'h5555_5555,32'hFFFF_FFFF, 32'h0000_000F, 32'hFFFF_FFF5, 1'b0};

    m = '0; active = 1'b1; rst = 1'b1;
    la1_in = 0; la2_in = 0; la3_in = 0; la1_oenb = 0; la2_oenb = 0; la3_oenb = 0; io_in = 0;

    cyc(1'b1, 1'b0, 3'd0, 32'd0);
    check_all("reset");

    for (int i = 0; i < 8; i++) begin
      wr(c_A, tv[i].a);
      wr(c_B, tv[i].b);
      wr(c_EXT, tv[i].ext);
      wr(c_RING, tv[i].ring);
      chk("table.sum", {6'd0, la1_out}, {6'd0, tv[i].exp_sum});
      chk("table.cout", {37'd0, io_out[10]}, {37'd0, tv[i].exp_co});
    end
    check_all("table");

    // Free-running chain toggles every cycle.
    cyc(1'b1, 1'b0, 3'd0, 32'd0);
    wr(c_RING, 32'h1); wr(c_S, 32'h1); wr(c_CTRL, 32'h3);
    for (int k = 0; k < 10; k++) idle();
    chk("chain.cycles", {6'd0, la3_out}, 38'd10);
`ifdef COUNTERS_EN
    chk("chain.toggle", {6'd0, la2_out}, 38'd10);
`else
    chk("chain.toggle", {6'd0, la2_out}, 38'd0);
`endif
    check_all("chain");

    // Tristate wrapper leaves state untouched.
    active = 1'b0;
    #1;
    zok = (la1_out === 32'bz) && (la2_out === 32'bz) && (la3_out === 32'bz) &&
          (io_out === 38'bz) && (io_oeb === 38'bz);
    chk("tristate", {37'd0, zok}, 38'd1);
    idle();
    idle();
    active = 1'b1;
    #1;
    check_all("reactivate");

    // Reset mid-run, with a competing write that must lose.
    rst = 1'b1;
    #1;
    chk("rst_comb.sum", {6'd0, la1_out}, 38'd0);
    chk("rst_comb.cycles", {6'd0, la3_out}, 38'd0);
    cyc(1'b1, 1'b1, c_B, 32'h0000_1234);
    check_all("midrst");
    chk("midrst.done_chain", {36'd0, io_out[9], io_out[8]}, 38'd0);
    idle();
    chk("midrst.write_lost", {6'd0, la1_out}, 38'd0);

    // Time limit of four counted cycles.
    wr(c_RING, 32'h1); wr(c_S, 32'h1); wr(c_TLIM, 32'd4); wr(c_CTRL, 32'h3);
    for (int k = 0; k < 4; k++) idle();
    chk("tlim.cycles4", {6'd0, la3_out}, 38'd4);
    chk("tlim.not_done", {37'd0, io_out[9]}, 38'd0);
    idle();
    chk("tlim.done", {37'd0, io_out[9]}, 38'd1);
    for (int k = 0; k < 3; k++) idle();
    chk("tlim.hold", {6'd0, la3_out}, 38'd4);
`ifdef COUNTERS_EN
    chk("tlim.toggle", {6'd0, la2_out}, 38'd4);
`endif
    check_all("tlim");

    // Random operands with the loop stopped.
    wr(c_CTRL, 32'h0);
    for (int k = 0; k < 20; k++) begin
      wr(c_A, $urandom);
      wr(c_B, $urandom);
      wr(c_EXT, $urandom);
      wr(c_RING, $urandom & $urandom);
      check_all("rand_add");
    end

    // Random runs with occasional writes while running.
    for (int r = 0; r < 6; r++) begin
      wr(c_A, $urandom); wr(c_B, $urandom); wr(c_EXT, $urandom);
      wr(c_RING, $urandom & $urandom); wr(c_S, $urandom);
      wr(c_TLIM, $urandom_range(0, 12));
      wr(c_CTRL, (r % 2 == 0) ? 32'h3 : 32'h1);
      for (int k = 0; k < 16; k++) begin
        if ($urandom_range(0, 7) == 0) wr(3'($urandom_range(0, 7)), $urandom);
        else idle();
        check_all("rand_run");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
